// File: rtl/prio_enc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prio_enc_pkg                                                 |
// | Description : Shared types and constants for the priority encoder/scanner. |
// |               ST_IDLE / ST_BUSY state encoding and the error counter       |
// |               width used by the optional lost-request counter.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package prio_enc_pkg;

    // Width of the saturating lost-request counter (PRIO_ENC_ERRCNT_EN builds).
    localparam int ERRCNT_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/prio_enc_lsb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prio_enc_lsb                                                 |
// | Description : Combinational lowest-set-bit finder.                         |
// |   Ports     : mask    - input bit vector, bit 0 has the highest priority   |
// |               code    - index of the lowest set bit (0 when mask is zero)  |
// |               any_set - at least one bit of mask is set                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module prio_enc_lsb
    import prio_enc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CODE_W = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0] mask,
    output logic [CODE_W-1:0] code,
    output logic              any_set
);

    // Scan from the top down so the last match written is the lowest index.
    always_comb begin
        code = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                code = CODE_W'(i);
            end
        end
    end

    assign any_set = |mask;

endmodule
`default_nettype wire

// File: rtl/prio_enc_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : prio_enc_scan                                                |
// | Description : Priority encoder with optional scan of all set bits.         |
// |               Accepts a word on in_valid/in_ready, then presents either    |
// |               the single lowest set bit (priority mode) or every set bit   |
// |               in ascending order (scan mode) on out_valid/out_ready.       |
// |   Ports     : clk, rst_n (async, active-low)                               |
// |               in_valid, in_ready, in_data, in_scan   - input word          |
// |               out_valid, out_ready, out_code,                              |
// |               out_zero, out_multi, out_last          - output codes        |
// |               err_cnt (only with PRIO_ENC_ERRCNT_EN) - saturating count of |
// |               multi-hot words accepted in priority mode                    |
// |   Macro     : PRIO_ENC_ERRCNT_EN enables err_cnt and its counter.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module prio_enc_scan
    import prio_enc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_scan,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DATA_W)-1:0]  out_code,
    output logic                       out_zero,
    output logic                       out_multi,
    output logic                       out_last
`ifdef PRIO_ENC_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0]        err_cnt
`endif
);

    localparam int CODE_W = $clog2(DATA_W);

    state_t             r_state;
    logic [DATA_W-1:0]  r_mask;     // residual: bits not yet emitted
    logic               r_scan;
    logic               r_zero;
    logic               r_multi;

    logic [CODE_W-1:0]  w_code;
    logic               w_any;
    logic [DATA_W-1:0]  w_rest;     // residual with its lowest set bit removed
    logic               w_in_multi;
    logic               w_accept;
    logic               w_out_hs;

    prio_enc_lsb #(
        .DATA_W (DATA_W),
        .CODE_W (CODE_W)
    ) u_lsb (
        .mask    (r_mask),
        .code    (w_code),
        .any_set (w_any)
    );

    // x & (x-1) drops the lowest set bit; a zero result means at most one bit.
    assign w_rest     = r_mask & (r_mask - DATA_W'(1));
    assign w_in_multi = |(in_data & (in_data - DATA_W'(1)));

    assign out_valid  = (r_state == ST_BUSY);
    assign out_code   = w_code;
    assign out_zero   = r_zero;
    assign out_multi  = r_multi;
    assign out_last   = out_valid && (!r_scan || !w_any || !(|w_rest));

    // Ready again in the same cycle the final code is taken: no bubble.
    assign in_ready   = !out_valid || (out_ready && out_last);
    assign w_accept   = in_valid && in_ready;
    assign w_out_hs   = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_scan  <= 1'b0;
            r_zero  <= 1'b0;
            r_multi <= 1'b0;
        end else if (w_accept) begin
            // Also covers final handshake coinciding with a new word.
            r_state <= ST_BUSY;
            r_mask  <= in_data;
            r_scan  <= in_scan;
            r_zero  <= ~|in_data;
            r_multi <= w_in_multi;
        end else if (w_out_hs) begin
            if (out_last) begin
                r_state <= ST_IDLE;
                r_mask  <= '0;
            end else begin
                r_mask  <= w_rest;
            end
        end
    end

`ifdef PRIO_ENC_ERRCNT_EN
    logic [ERRCNT_W-1:0] r_err_cnt;

    // A multi-hot word in priority mode drops every request but the lowest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_accept && !in_scan && w_in_multi && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`else
    // Lost-request counter not built.
`endif

endmodule
`default_nettype wire

// File: doc/prio_enc_scan.md
PRIO_ENC_SCAN -- requirements
Module: prio_enc_scan

Interface
REQ-001 SHALL have parameter DATA_W, default 8, input word width (2..64).
REQ-002 SHALL have localparam CODE_W, value $clog2(DATA_W), output code width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  input word offered.
REQ-006 SHALL have port in_ready  output  1  block accepts word this cycle.
REQ-007 SHALL have port in_data  input  DATA_W  request bits, bit 0 highest priority.
REQ-008 SHALL have port in_scan  input  1  mode for the word: 0 = priority, 1 = scan all set bits.
REQ-009 SHALL have port out_valid  output  1  code presented.
REQ-010 SHALL have port out_ready  input  1  consumer takes code.
REQ-011 SHALL have port out_code  output  CODE_W  index of lowest set bit remaining.
REQ-012 SHALL have port out_zero  output  1  accepted word was all-zero.
REQ-013 SHALL have port out_multi  output  1  accepted word had more than one bit set.
REQ-014 SHALL have port out_last  output  1  final code for the accepted word.

Function
REQ-015 SHALL accept a word when in_valid && in_ready; the transfer SHALL occur on that rising edge.
REQ-016 SHALL drive in_ready = !out_valid || (out_ready && out_last), allowing back-to-back words with no bubble.
REQ-017 SHALL present the first code one cycle after acceptance (latency 1).
REQ-018 SHALL hold a residual mask; states IDLE (no word) and BUSY (word held). IDLE->BUSY on accept; BUSY->IDLE on the out handshake with out_last=1 and no new accept.
REQ-019 In priority mode SHALL emit exactly one code (lowest set bit), with out_last=1.
REQ-020 In scan mode SHALL emit one code per set bit, ascending; on each out handshake with out_last=0 it SHALL clear the emitted bit and present the next code on the following cycle with out_valid held high.
REQ-021 out_last SHALL be 1 when the residual has at most one set bit, or when the word is in priority mode.
REQ-022 For an all-zero word SHALL emit a single code 0 with out_zero=1 and out_last=1 in either mode.
REQ-023 out_zero and out_multi SHALL be computed from the accepted word and held constant for all of that word's codes.
REQ-024 While out_valid && !out_ready, out_code, out_zero, out_multi, and out_last SHALL remain stable.
REQ-025 On a simultaneous final handshake and new accept, the new word's first code SHALL appear on the next cycle.

Reset
REQ-026 On rst_n low, the block SHALL go IDLE immediately with out_valid=0, out_code=0, out_zero=0, out_multi=0, out_last=0, and the residual cleared.
REQ-027 Reset mid-scan SHALL discard the remaining codes; in_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-028 With macro PRIO_ENC_ERRCNT_EN defined, port err_cnt output 16 SHALL exist: a saturating count of accepted multi-hot words in priority mode (lost requests), reset to 0.
REQ-029 Without PRIO_ENC_ERRCNT_EN, port err_cnt and its counter SHALL be absent, with all other behaviour identical.

Structure
REQ-030 Package prio_enc_pkg SHALL hold the state enum (ST_IDLE, ST_BUSY) and the ERRCNT_W=16 constant.
REQ-031 Sub-module prio_enc_lsb (combinational lowest-set-bit finder: mask in -> code and any-set out) SHALL be instantiated once on the residual.

Verification (DATA_W=8)
REQ-032 Walking one, 0x01 to 0x80, priority mode, out_ready=1 -> codes 0..7, one per cycle, latency 1, out_multi=0, out_last=1.
REQ-033 Scan mode, 0xA4 -> codes 2, 5, 7 on three consecutive cycles; out_last only on 7; out_multi=1; in_ready low for 2 cycles.
REQ-034 Priority mode, 0xA4 -> single code 2 with out_multi=1; with the macro defined, err_cnt increments by 1.
REQ-035 Input 0x00 in scan mode -> one code 0 with out_zero=1 and out_last=1.
REQ-036 Scan mode 0x81 with out_ready low for 3 cycles -> code 0 held stable, then 7 once out_ready rises; no code is lost or duplicated.
REQ-037 Reset asserted after the first code of 0xFF in scan mode -> out_valid=0 immediately; no further codes; the next word is accepted normally.
